axil_intr_ctrl: RTL and testbench
=================================

AXIL_INTR_CTRL -- requirements
Module: axil_intr_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of interrupt channels, legal range 1..32.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width, fixed at 32.
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 5: byte-address width, minimum 5.
REQ-004 Parameter IRQ_ACTIVE_STATE, default 1: level driven on irq when asserted.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth on intr_in, legal range 2..4.
REQ-006 S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-007 S_AXI_ARESETN  in  1  asynchronous, active-low reset.
REQ-008 S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave channels: AWADDR/ARADDR C_S_AXI_ADDR_WIDTH, AWPROT/ARPROT 3 (ignored), WDATA/RDATA 32, WSTRB 4, BRESP/RRESP 2, plus VALID/READY per channel.
REQ-009 intr_in  in  NUM_IRQ  asynchronous interrupt sources.
REQ-010 irq  out  1  combined interrupt request.

Function
REQ-011 Register map, word-aligned, address bits [1:0] ignored: 0x00 GIE (bit0); 0x04 IER enable [NUM_IRQ-1:0]; 0x08 ISR status (RO); 0x0C IAR acknowledge (W1C, reads 0); 0x10 IPR pending = ISR & IER (RO); 0x14 ITR soft trigger (WO, reads 0); 0x18 IMR mode per channel (1 = rising edge, 0 = level).
REQ-012 Write handshake: AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID; the register updates on that edge; BVALID rises the next cycle and holds until BREADY; BRESP = OKAY.
REQ-013 Read handshake: ARREADY pulses for one cycle when ARVALID & !RVALID; RDATA is captured on that edge; RVALID rises the next cycle and holds, with RDATA stable, until RREADY; RRESP = OKAY.
REQ-014 Undecoded offsets return OKAY; writes to them are ignored and reads return 0.
REQ-015 WSTRB byte lanes qualify every write; unstrobed bytes are neither updated nor acknowledged.
REQ-016 Bits at index NUM_IRQ and above read as 0 and ignore writes.
REQ-017 intr_in passes through SYNC_STAGES flops before any use.
REQ-018 Edge channel: the ISR bit sets on a synchronised 0->1 transition and holds until acknowledged.
REQ-019 Level channel: the ISR bit sets each cycle the synchronised input is high; an acknowledge clears it, but it re-sets on the next cycle if the input is still high.
REQ-020 A set event and an IAR clear on the same edge leave the ISR bit set.
REQ-021 The ISR is updated regardless of IER and GIE.
REQ-022 irq is registered: asserted (IRQ_ACTIVE_STATE) one cycle after GIE & |IPR becomes true; deasserted one cycle after it becomes false.
REQ-023 Interrupt latency from an intr_in edge to irq equals SYNC_STAGES + 2 cycles.
REQ-024 A change to IMR takes effect on the next cycle; no spurious edge is generated by the change.

Reset
REQ-025 Asserting S_AXI_ARESETN low immediately clears GIE, IER, ISR, IMR, the synchronisers, AWREADY, WREADY, BVALID, ARREADY and RVALID, and drives irq to !IRQ_ACTIVE_STATE.
REQ-026 A reset during an outstanding transaction abandons it; no BVALID or RVALID follows deassertion.
REQ-027 The first edge detection after reset treats the previous synchronised value as 0.

Configuration
REQ-028 With INTR_SOFT_TRIGGER_EN defined, a write of 1 to an ITR bit sets the matching ISR bit on the same edge as the write, regardless of IMR; writing 0 has no effect.
REQ-029 Without INTR_SOFT_TRIGGER_EN, offset 0x14 behaves as undecoded and no trigger logic is built.

Verification
REQ-030 NUM_IRQ=4: write GIE=1 and IER=0x1, then pulse intr_in[0] high for 3 cycles -> irq active 4 cycles after the rising edge, and IPR reads 0x1.
REQ-031 Write IAR=0x1 with edge mode and intr_in[0] low -> irq inactive 1 cycle after the write, and IPR reads 0x0.
REQ-032 IMR=0x0 with intr_in[1] held high: write IAR=0x2 -> ISR[1] reads back 1, and irq stays active.
REQ-033 Rising edge on intr_in[2] coinciding with an IAR=0x4 write -> ISR[2] remains 1.
REQ-034 BREADY and RREADY held low for 10 cycles -> BVALID/RVALID and RDATA are stable throughout, and no second AWREADY or ARREADY occurs.
REQ-035 With INTR_SOFT_TRIGGER_EN and GIE=1, IER=0x8: write ITR=0x8 -> ISR reads 0x8 and irq is active; without the macro, the same write leaves ISR at 0x0.

Source files
------------

// File: rtl/axil_intr_ctrl.sv
// AXI4-Lite interrupt controller with synchronised edge/level sources and a combined irq.
// Define INTR_SOFT_TRIGGER_EN to build the ITR soft-trigger register at offset 0x14.
module axil_intr_ctrl #(
  parameter int NUM_IRQ            = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IRQ_ACTIVE_STATE   = 1,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [NUM_IRQ-1:0]                intr_in,
  output logic                              irq
);

  localparam int   IW     = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic IRQ_ON = 1'(IRQ_ACTIVE_STATE);

  typedef enum logic [2:0] {
    REG_GIE = 3'd0, REG_IER = 3'd1, REG_ISR = 3'd2, REG_IAR = 3'd3,
    REG_IPR = 3'd4, REG_ITR = 3'd5, REG_IMR = 3'd6
  } reg_e;

  function automatic logic hit(input logic [IW-1:0] idx, input reg_e r);
    return idx == IW'(r);
  endfunction

  logic                             wr_ready, b_valid, ar_ready, r_valid, irq_q;
  logic [31:0]                      r_data, rd_mux, wmask;
  logic                             gie;
  logic [NUM_IRQ-1:0]               ier, isr, imr, sync_prev;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_ff;
  logic [NUM_IRQ-1:0]               sync_q, rise, trig, isr_set, isr_clr, isr_next;
  logic [NUM_IRQ-1:0]               wdata_n, wkeep;
  logic [IW-1:0]                    wsel, rsel;
  logic                             wr_en;

  wire unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

  assign wr_en   = wr_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign wsel    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rsel    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign sync_q  = sync_ff[SYNC_STAGES-1];
  assign wdata_n = S_AXI_WDATA[NUM_IRQ-1:0];
  assign wkeep   = wmask[NUM_IRQ-1:0];

  always_comb begin
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
  end

`ifdef INTR_SOFT_TRIGGER_EN
  assign trig = (wr_en && hit(wsel, REG_ITR)) ? (wdata_n & wkeep) : '0;
`else
  assign trig = '0;
`endif

  // A set event on the same edge as an acknowledge wins, so no interrupt is lost.
  always_comb begin
    rise     = sync_q & ~sync_prev;
    isr_set  = (imr & rise) | (~imr & sync_q) | trig;
    isr_clr  = (wr_en && hit(wsel, REG_IAR)) ? (wdata_n & wkeep) : '0;
    isr_next = (isr & ~isr_clr) | isr_set;
  end

  always_comb begin
    // NOTE: default every output of a combinational block first; a path that skips an assignment infers a latch.
    rd_mux = '0;
    case (rsel)
      IW'(REG_GIE): rd_mux[0]           = gie;
      IW'(REG_IER): rd_mux[NUM_IRQ-1:0] = ier;
      IW'(REG_ISR): rd_mux[NUM_IRQ-1:0] = isr;
      IW'(REG_IPR): rd_mux[NUM_IRQ-1:0] = isr & ier;
      IW'(REG_IMR): rd_mux[NUM_IRQ-1:0] = imr;
      default:      rd_mux              = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_ready <= 1'b0;
      b_valid  <= 1'b0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      wr_ready <= S_AXI_AWVALID && S_AXI_WVALID && !b_valid && !wr_ready;
      if (wr_en)                       b_valid <= 1'b1;
      else if (b_valid && S_AXI_BREADY) b_valid <= 1'b0;

      ar_ready <= S_AXI_ARVALID && !r_valid && !ar_ready;
      if (ar_ready && S_AXI_ARVALID) begin
        r_valid <= 1'b1;
        r_data  <= rd_mux;
      end else if (r_valid && S_AXI_RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync_ff   <= '0;
      sync_prev <= '0;
      gie       <= 1'b0;
      ier       <= '0;
      imr       <= '0;
      isr       <= '0;
      irq_q     <= ~IRQ_ON;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], intr_in};
      sync_prev <= sync_q;
      if (wr_en && hit(wsel, REG_GIE) && S_AXI_WSTRB[0]) gie <= S_AXI_WDATA[0];
      if (wr_en && hit(wsel, REG_IER)) ier <= (ier & ~wkeep) | (wdata_n & wkeep);
      if (wr_en && hit(wsel, REG_IMR)) imr <= (imr & ~wkeep) | (wdata_n & wkeep);
      isr   <= isr_next;
      irq_q <= (gie && |(isr & ier)) ? IRQ_ON : ~IRQ_ON;
    end
  end

  assign S_AXI_AWREADY = wr_ready;
  assign S_AXI_WREADY  = wr_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

endmodule

// File: tb/tb_axil_intr_ctrl.sv
// Directed bench for axil_intr_ctrl: register reads go through an expected-value queue,
// irq timing and handshake behaviour are checked cycle by cycle.
module tb_axil_intr_ctrl;

  localparam logic [4:0] A_GIE = 5'h00, A_IER = 5'h04, A_ISR = 5'h08, A_IAR = 5'h0C;
  localparam logic [4:0] A_IPR = 5'h10, A_ITR = 5'h14, A_IMR = 5'h18, A_UND = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  intr_in;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef INTR_SOFT_TRIGGER_EN
  localparam logic [31:0] TRIG_ISR = 32'h8;
  localparam logic [31:0] TRIG_IRQ = 32'h1;
`else
  localparam logic [31:0] TRIG_ISR = 32'h0;
  localparam logic [31:0] TRIG_IRQ = 32'h0;
`endif

  axil_intr_ctrl #(
    .NUM_IRQ(4), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
    .IRQ_ACTIVE_STATE(1), .SYNC_STAGES(2)
  ) dut (
    .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),   .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),   .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
    .intr_in(intr_in),      .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_awready"}, 32'(awready & wready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_bvalid"}, {29'h0, awready, bresp, bvalid}, 32'h1);
  endtask

  task automatic axi_read(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_arready"}, 32'(arready), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check({tag, "_rvalid"}, {29'h0, arready, rresp, rvalid}, 32'h1);
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst_n = 1'b0; intr_in = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'h0, irq, awready, bvalid, arready, rvalid}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    axi_read("reset_gie", A_GIE, 32'h0);
    axi_read("reset_ier", A_IER, 32'h0);
    axi_read("reset_imr", A_IMR, 32'h0);

    // Channel 0 and 2 edge-triggered, 1 and 3 level.
    axi_write("w_gie", A_GIE, 32'h1, 4'hF);
    axi_write("w_ier", A_IER, 32'h1, 4'hF);
    axi_write("w_imr", A_IMR, 32'h5, 4'hF);

    @(negedge clk); intr_in[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("latency_irq_c%0d", i), 32'(irq), (i == 4) ? 32'h1 : 32'h0);
      if (i == 3) intr_in[0] = 1'b0;
    end
    axi_read("edge_ipr", A_IPR, 32'h1);
    axi_read("edge_isr", A_ISR, 32'h1);

    axi_write("ack0", A_IAR, 32'h1, 4'hF);
    check("ack0_irq_still", 32'(irq), 32'h1);
    @(posedge clk); #1;
    check("ack0_irq_drop", 32'(irq), 32'h0);
    axi_read("ack0_ipr", A_IPR, 32'h0);

    axi_write("ier3", A_IER, 32'h3, 4'hF);
    @(negedge clk); intr_in[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("level_irq", 32'(irq), 32'h1);
    axi_write("ack1_level", A_IAR, 32'h2, 4'hF);
    check("ack1_irq_w", 32'(irq), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("ack1_irq_hold", 32'(irq), 32'h1);
    axi_read("level_isr", A_ISR, 32'h2);
    @(negedge clk); intr_in[1] = 1'b0;
    repeat (4) @(posedge clk);
    axi_write("ack1_final", A_IAR, 32'h2, 4'hF);
    axi_read("level_clr_isr", A_ISR, 32'h0);
    @(posedge clk); #1;
    check("level_clr_irq", 32'(irq), 32'h0);

    // Edge on channel 2 reaches the ISR on the same edge as the IAR write.
    @(negedge clk); intr_in[2] = 1'b1;
    @(negedge clk);
    awaddr = A_IAR; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("coinc_awready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read("coinc_isr", A_ISR, 32'h4);
    intr_in[2] = 1'b0;
    axi_write("ack2", A_IAR, 32'h4, 4'hF);
    axi_read("ack2_isr", A_ISR, 32'h0);

    @(negedge clk); intr_in[3] = 1'b1;
    repeat (4) @(posedge clk);
    axi_read("lvl3_isr", A_ISR, 32'h8);
    axi_write("imr_d", A_IMR, 32'hD, 4'hF);
    axi_write("ack3", A_IAR, 32'h8, 4'hF);
    repeat (3) @(posedge clk);
    axi_read("mode_switch_isr", A_ISR, 32'h0);
    intr_in[3] = 1'b0;

    axi_write("ier_strb", A_IER, 32'hF, 4'h2);
    axi_read("ier_strb_rd", A_IER, 32'h3);
    axi_write("ier_all", A_IER, 32'hFFFF_FFFF, 4'hF);
    axi_read("ier_upper_rd", A_IER, 32'hF);
    axi_write("undec", A_UND, 32'hFFFF_FFFF, 4'hF);
    axi_read("undec_rd", A_UND, 32'h0);
    axi_read("iar_rd", A_IAR, 32'h0);
    axi_read("itr_rd", A_ITR, 32'h0);
    axi_read("imr_rd", A_IMR, 32'hD);

    // Response channels stalled for 10 cycles while a new request is presented.
    bready = 1'b0;
    @(negedge clk);
    awaddr = A_GIE; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("stall_w_awready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_b_%0d", i), {30'h0, awready, bvalid}, 32'h1);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("stall_b_release", 32'(bvalid), 32'h0);

    rready = 1'b0;
    exp_q.push_back(32'hF);
    tag_q.push_back("stall_r_data");
    @(negedge clk);
    araddr = A_IER; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("stall_r_arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    held = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_r_%0d", i), {30'h0, arready, rvalid}, 32'h1);
      check(tag_q[0], rdata, held);
    end
    void'(tag_q.pop_front());
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    check("stall_r_release", 32'(rvalid), 32'h0);

    axi_write("ier8", A_IER, 32'h8, 4'hF);
    axi_write("itr8", A_ITR, 32'h8, 4'hF);
    axi_read("itr_isr", A_ISR, TRIG_ISR);
    check("itr_irq", 32'(irq), TRIG_IRQ);

    // Reset lands while a read response is outstanding.
    rready = 1'b0;
    @(negedge clk);
    araddr = A_IER; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rst_pre_rvalid", 32'(rvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {27'h0, irq, awready, bvalid, arready, rvalid}, 32'h0);
    @(negedge clk); rst_n = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_rvalid", {30'h0, rvalid, bvalid}, 32'h0);
    axi_read("rst_gie", A_GIE, 32'h0);
    axi_read("rst_isr", A_ISR, 32'h0);
    axi_read("rst_imr", A_IMR, 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
